cdb_arbiter: RTL and testbench

Round-robin arbiter for the common data bus of the reservation-station core. The add, mul, lw and mv/spare execution slots each raise a broadcast request carrying a producer tag and a result word. One request is granted per cycle and driven onto a registered CDB that the reservation entries and the register-result-status table snoop. This replaces the shared `cdb`/`cdbchange` write race with a single sequenced owner.

---
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin owner of the common data bus.
//
// The execution slots (0=add, 1=mul, 2=lw, 3=mv/spare) each raise a broadcast
// request carrying a producer tag and a result word. One request is granted per
// cycle and driven onto a registered CDB. The reservation entries and the
// register-result-status table snoop that CDB.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester broadcast request            [N_REQ]
//   req_tag      packed producer tags, slot i at [i*UNIT_SIZE +: UNIT_SIZE]
//   req_data     packed result words, slot i at [i*WORD_SIZE +: WORD_SIZE]
//   flush        synchronous squash: no grant, pointer back to slot 0
//   req_grant    combinational one-hot/zero grant; consumed at the next edge
//   cdb_valid    registered broadcast strobe
//   cdb_tag      registered producer tag
//   cdb_data     registered result word
//   tag_err      sticky: a request carrying READY_TAG was granted
//   bcast_count  wrapping count of legal broadcasts
module cdb_arbiter #(
    parameter int unsigned          N_REQ     = 4,
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          UNIT_SIZE = 8,
    parameter logic [UNIT_SIZE-1:0] READY_TAG = 8'h7F
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UNIT_SIZE-1:0]   req_tag,
    input  logic [N_REQ*WORD_SIZE-1:0]   req_data,
    input  logic                         flush,
    output logic [N_REQ-1:0]             req_grant,
    output logic                         cdb_valid,
    output logic [UNIT_SIZE-1:0]         cdb_tag,
    output logic [WORD_SIZE-1:0]         cdb_data,
    output logic                         tag_err,
    output logic [15:0]                  bcast_count
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned COUNT_W = 16;

    // Broadcast payload as it sits on the bus.
    typedef struct packed {
        logic                 valid;
        logic [UNIT_SIZE-1:0] tag;
        logic [WORD_SIZE-1:0] data;
    } cdb_bcast_t;

    // Per-slot views of the packed request buses.
    logic [UNIT_SIZE-1:0] tag_arr  [N_REQ];
    logic [WORD_SIZE-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign tag_arr[i]  = req_tag[i*UNIT_SIZE +: UNIT_SIZE];
        assign data_arr[i] = req_data[i*WORD_SIZE +: WORD_SIZE];
    end

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    cdb_bcast_t         cdb_q, cdb_d;
    logic               tag_err_q, tag_err_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic [N_REQ-1:0]   grant_c;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic               gnt_any;

    // Grant: first requester at or after ptr, wrapping; blocked by flush and reset.
    always_comb begin
        grant_c  = '0;
        gnt_idx  = '0;
        scan_idx = '0;
        gnt_any  = 1'b0;
        if (rst_n && !flush) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_idx = PTR_W'((32'(ptr_q) + k) % N_REQ);
                if (!gnt_any && req_valid[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
            if (gnt_any) begin
                grant_c[gnt_idx] = 1'b1;
            end
        end
    end

    assign req_grant = grant_c;

    // Next state: advance past the winner, broadcast unless the tag is reserved.
    always_comb begin
        ptr_d       = ptr_q;
        cdb_d       = cdb_q;
        cdb_d.valid = 1'b0;
        tag_err_d   = tag_err_q;
        count_d     = count_q;
        if (flush) begin
            ptr_d = '0;
        end else if (gnt_any) begin
            ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (tag_arr[gnt_idx] == READY_TAG) begin
                // Reserved tag is consumed but never reaches the bus.
                tag_err_d = 1'b1;
            end else begin
                cdb_d.valid = 1'b1;
                cdb_d.tag   = tag_arr[gnt_idx];
                cdb_d.data  = data_arr[gnt_idx];
                count_d     = count_q + COUNT_W'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cdb_q     <= '0;
            tag_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cdb_q     <= cdb_d;
            tag_err_q <= tag_err_d;
            count_q   <= count_d;
        end
    end

    assign cdb_valid   = cdb_q.valid;
    assign cdb_tag     = cdb_q.tag;
    assign cdb_data    = cdb_q.data;
    assign tag_err     = tag_err_q;
    assign bcast_count = count_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed steps from the test plan, then a randomized
// stream of well-behaved requesters checked against a behavioural model.
module tb_cdb_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_tag;
    logic [127:0] req_data;
    logic        flush;
    logic [3:0]  req_grant;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        tag_err;
    logic [15:0] bcast_count;

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .flush       (flush),
        .req_grant   (req_grant),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .tag_err     (tag_err),
        .bcast_count (bcast_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester side: pending requests held until granted.
    bit          pend  [N];
    logic [7:0]  ptag  [N];
    logic [31:0] pdata [N];
    int          waitc [N];
    bit          fl;

    // Reference model state.
    int          m_ptr;
    bit          m_valid;
    logic [7:0]  m_tag;
    logic [31:0] m_data;
    bit          m_err;
    int          m_count;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_tag[i*8 +: 8]   = ptag[i];
            req_data[i*32 +: 32] = pdata[i];
        end
        flush = fl;
    endtask

    function automatic int model_winner();
        if (!rst_n || fl) return -1;
        for (int k = 0; k < N; k++) begin
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, ".valid"}, 64'(cdb_valid), 64'(m_valid));
        if (m_valid) begin
            check({pfx, ".tag"},  64'(cdb_tag),  64'(m_tag));
            check({pfx, ".data"}, 64'(cdb_data), 64'(m_data));
        end
        check({pfx, ".err"},   64'(tag_err),     64'(m_err));
        check({pfx, ".count"}, 64'(bcast_count), 64'(m_count));
    endtask

    // One clock cycle: entered at posedge+1, returns at the next posedge+1.
    task automatic cycle(input string pfx);
        int w;
        logic [3:0] exp_g;
        drive();
        #2;
        w = model_winner();
        exp_g = (w < 0) ? 4'b0000 : 4'(1 << w);
        check({pfx, ".grant"}, 64'(req_grant), 64'(exp_g));
        if (w >= 0) check({pfx, ".fair"}, 64'(waitc[w] <= N - 1), 64'd1);
        @(posedge clk);
        if (fl) begin
            m_ptr = 0; m_valid = 0;
        end else if (w >= 0) begin
            m_ptr = (w + 1) % N;
            if (ptag[w] == 8'h7F) begin
                m_valid = 0; m_err = 1;
            end else begin
                m_valid = 1; m_tag = ptag[w]; m_data = pdata[w];
                m_count = (m_count + 1) % 65536;
            end
        end else begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (i == w)          begin pend[i] = 0; waitc[i] = 0; end
            else if (pend[i] && !fl) waitc[i]++;
            else                 waitc[i] = 0;
        end
        #1;
        check_outputs(pfx);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_tag = '0; m_data = '0; m_err = 0; m_count = 0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; ptag[i] = '0; pdata[i] = '0; waitc[i] = 0;
        end
        fl = 0;
        drive();
    endtask

    // Full reset pulse, returning aligned at posedge+1 with idle inputs.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst.grant", 64'(req_grant), 64'd0);
        check_outputs("rst");
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] t, input logic [31:0] d);
        pend[i] = 1; ptag[i] = t; pdata[i] = d;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_reqs();
        model_reset();

        // Reset with every request raised.
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h10 + i), 32'(i));
        drive();
        repeat (2) @(posedge clk);
        #3;
        check("reset.grant", 64'(req_grant), 64'd0);
        check_outputs("reset");
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request from slot 1.
        set_req(1, 8'h40, 32'd7);
        cycle("single");
        check("single.const_tag", 64'(cdb_tag), 64'h40);
        cycle("single.idle");

        // All four from reset: order 0,1,2,3, continuous valid.
        reset_pulse();
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h20 + i), 32'(32'hA000 + i));
        for (int k = 0; k < N; k++) begin
            cycle("all4");
            check("all4.tag_seq", 64'(cdb_tag), 64'(8'h20 + k));
        end
        cycle("all4.idle");

        // Slots 0 and 2 held continuously: alternate.
        for (int k = 0; k < 6; k++) begin
            if (!pend[0]) set_req(0, 8'(8'h30 + k), $urandom);
            if (!pend[2]) set_req(2, 8'(8'h50 + k), $urandom);
            cycle("alt");
        end
        clear_reqs();
        cycle("alt.drain");
        cycle("alt.idle");

        // Reserved tag on slot 2.
        set_req(2, 8'h7F, 32'hDEAD);
        cycle("ready");
        check("ready.err_const", 64'(tag_err), 64'd1);
        cycle("ready.sticky");

        // Flush with three pending, then slot 0 wins.
        set_req(0, 8'h61, 32'd1);
        set_req(1, 8'h62, 32'd2);
        set_req(3, 8'h63, 32'd3);
        fl = 1;
        cycle("flush");
        fl = 0;
        cycle("flush.after");
        check("flush.slot0", 64'(cdb_tag), 64'h61);

        // Reset in the middle of a live broadcast.
        set_req(3, 8'h64, 32'd4);
        cycle("midrst.pre");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst.grant", 64'(req_grant), 64'd0);
        check_outputs("midrst");
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized requesters with occasional flushes and reserved tags.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 4) begin
                    set_req(i, ($urandom_range(0, 9) == 0) ? 8'h7F : 8'($urandom), $urandom);
                end
            end
            fl = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
